// File: rtl/demux_lane_scheduler.sv
// Credit-based round-robin scheduler steering one valid-qualified byte stream onto two lanes.
// Each lane holds a credit per free downstream slot; the source is back-pressured when both run dry.
module demux_lane_scheduler #(
    parameter int unsigned CREDITS = 4,
    parameter int unsigned CW      = 4
) (
    input  logic          clk_2f,
    input  logic          reset,
    input  logic [7:0]    data_in,
    input  logic          valid_in,
    output logic          ready_in,
    input  logic          pop_0,
    input  logic          pop_1,
    output logic [7:0]    data_out_0,
    output logic [7:0]    data_out_1,
    output logic          valid_out_0,
    output logic          valid_out_1,
    output logic          lane_sel,
    output logic [CW-1:0] credit_0,
    output logic [CW-1:0] credit_1,
    output logic          err_drop,
    output logic          err_credit
);

    localparam logic [CW-1:0] CreditMax = CW'(CREDITS);

    typedef enum logic [1:0] {
        StPref0,
        StPref1,
        StStall
    } state_e;

    state_e        state_q, state_d;
    logic          pref_q, pref_d;
    logic          last_q, last_d;
    logic [CW-1:0] credit0_q, credit0_d;
    logic [CW-1:0] credit1_q, credit1_d;
    logic [7:0]    data0_q, data0_d;
    logic [7:0]    data1_q, data1_d;
    logic          valid0_q, valid0_d;
    logic          valid1_q, valid1_d;
    logic          err_drop_q, err_drop_d;
    logic          err_credit_q, err_credit_d;

    logic          ready;
    logic          accept;
    logic          target;
    logic          push0, push1;
    logic          over0, over1;

    // ready depends only on registered credits, never on valid_in
    assign ready  = !reset && ((credit0_q != '0) || (credit1_q != '0));
    assign accept = valid_in && ready;

    always_comb begin
        target = pref_q;
        unique case (state_q)
            StPref0: target = (credit0_q != '0) ? 1'b0 : 1'b1;
            StPref1: target = (credit1_q != '0) ? 1'b1 : 1'b0;
            default: target = pref_q;
        endcase
    end

    assign push0 = accept && (target == 1'b0);
    assign push1 = accept && (target == 1'b1);

    // A return on a full lane is a sink protocol error; the credit saturates
    assign over0 = pop_0 && !push0 && (credit0_q == CreditMax);
    assign over1 = pop_1 && !push1 && (credit1_q == CreditMax);

    always_comb begin
        credit0_d = credit0_q;
        if (push0 && !pop_0) begin
            credit0_d = credit0_q - 1'b1;
        end else if (pop_0 && !push0 && !over0) begin
            credit0_d = credit0_q + 1'b1;
        end
    end

    always_comb begin
        credit1_d = credit1_q;
        if (push1 && !pop_1) begin
            credit1_d = credit1_q - 1'b1;
        end else if (pop_1 && !push1 && !over1) begin
            credit1_d = credit1_q + 1'b1;
        end
    end

    always_comb begin
        data0_d  = data0_q;
        data1_d  = data1_q;
        valid0_d = 1'b0;
        valid1_d = 1'b0;
        if (push0) begin
            data0_d  = data_in;
            valid0_d = 1'b1;
        end
        if (push1) begin
            data1_d  = data_in;
            valid1_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pref_d  = pref_q;
        last_d  = last_q;
        if (accept) begin
            pref_d = ~target;
            last_d = target;
        end
        if ((credit0_d == '0) && (credit1_d == '0)) begin
            state_d = StStall;
        end else begin
            if (state_q == StStall) begin
                // Resume on whichever lane got credit back; on a tie, rotate past last served
                if ((credit0_d != '0) && (credit1_d != '0)) begin
                    pref_d = ~last_q;
                end else begin
                    pref_d = (credit1_d != '0);
                end
            end
            state_d = pref_d ? StPref1 : StPref0;
        end
    end

    always_comb begin
        err_drop_d   = err_drop_q | (valid_in & ~ready);
        err_credit_d = err_credit_q | over0 | over1;
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q      <= StPref0;
            pref_q       <= 1'b0;
            last_q       <= 1'b1;
            credit0_q    <= CreditMax;
            credit1_q    <= CreditMax;
            data0_q      <= 8'h00;
            data1_q      <= 8'h00;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            err_drop_q   <= 1'b0;
            err_credit_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pref_q       <= pref_d;
            last_q       <= last_d;
            credit0_q    <= credit0_d;
            credit1_q    <= credit1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            err_drop_q   <= err_drop_d;
            err_credit_q <= err_credit_d;
        end
    end

    assign ready_in    = ready;
    assign lane_sel    = target;
    assign data_out_0  = data0_q;
    assign data_out_1  = data1_q;
    assign valid_out_0 = valid0_q;
    assign valid_out_1 = valid1_q;
    assign credit_0    = credit0_q;
    assign credit_1    = credit1_q;
    assign err_drop    = err_drop_q;
    assign err_credit  = err_credit_q;

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Directed bench for demux_lane_scheduler: alternation, stall/drop, credit return, errors, reset.
module tb_demux_lane_scheduler;

    logic       clk_2f = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_in;
    logic       pop_0;
    logic       pop_1;
    logic [7:0] data_out_0;
    logic [7:0] data_out_1;
    logic       valid_out_0;
    logic       valid_out_1;
    logic       lane_sel;
    logic [3:0] credit_0;
    logic [3:0] credit_1;
    logic       err_drop;
    logic       err_credit;

    int total = 0;
    int bad   = 0;

    demux_lane_scheduler #(
        .CREDITS(4),
        .CW     (4)
    ) dut (
        .clk_2f     (clk_2f),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .pop_0      (pop_0),
        .pop_1      (pop_1),
        .data_out_0 (data_out_0),
        .data_out_1 (data_out_1),
        .valid_out_0(valid_out_0),
        .valid_out_1(valid_out_1),
        .lane_sel   (lane_sel),
        .credit_0   (credit_0),
        .credit_1   (credit_1),
        .err_drop   (err_drop),
        .err_credit (err_credit)
    );

    always #5 clk_2f = ~clk_2f;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic step();
        @(posedge clk_2f);
        #1;
    endtask

    initial begin
        logic [7:0] bytes_b [4];
        bytes_b[0] = 8'hB1;
        bytes_b[1] = 8'hB2;
        bytes_b[2] = 8'hB3;
        bytes_b[3] = 8'hB4;

        reset    = 1'b1;
        data_in  = 8'h00;
        valid_in = 1'b0;
        pop_0    = 1'b0;
        pop_1    = 1'b0;
        step();
        step();
        chk("ready_in_during_reset", ready_in, 0);
        reset = 1'b0;
        #1;
        chk("rst_credit_0", credit_0, 4);
        chk("rst_credit_1", credit_1, 4);
        chk("rst_ready_in", ready_in, 1);
        chk("rst_valid_out_0", valid_out_0, 0);
        chk("rst_valid_out_1", valid_out_1, 0);
        chk("rst_data_out_0", data_out_0, 8'h00);
        chk("rst_data_out_1", data_out_1, 8'h00);
        chk("rst_lane_sel", lane_sel, 0);
        chk("rst_err_drop", err_drop, 0);
        chk("rst_err_credit", err_credit, 0);

        // A1..A4: strict alternation starting on lane 0
        valid_in = 1'b1;
        data_in  = 8'hA1;
        chk("a1_lane_sel", lane_sel, 0);
        step();
        chk("a1_valid_out_0", valid_out_0, 1);
        chk("a1_data_out_0", data_out_0, 8'hA1);
        chk("a1_valid_out_1", valid_out_1, 0);
        chk("a1_credit_0", credit_0, 3);
        data_in = 8'hA2;
        chk("a2_lane_sel", lane_sel, 1);
        step();
        chk("a2_valid_out_1", valid_out_1, 1);
        chk("a2_data_out_1", data_out_1, 8'hA2);
        chk("a2_valid_out_0", valid_out_0, 0);
        chk("a2_data_out_0_held", data_out_0, 8'hA1);
        data_in = 8'hA3;
        step();
        chk("a3_valid_out_0", valid_out_0, 1);
        chk("a3_data_out_0", data_out_0, 8'hA3);
        chk("a3_data_out_1_held", data_out_1, 8'hA2);
        data_in = 8'hA4;
        step();
        chk("a4_valid_out_1", valid_out_1, 1);
        chk("a4_data_out_1", data_out_1, 8'hA4);
        chk("a4_credit_0", credit_0, 2);
        chk("a4_credit_1", credit_1, 2);

        // B1..B4 drain the remaining credits
        for (int i = 0; i < 4; i++) begin
            data_in = bytes_b[i];
            step();
            if (i % 2 == 0) begin
                chk("b_even_valid_out_0", valid_out_0, 1);
                chk("b_even_data_out_0", data_out_0, bytes_b[i]);
            end else begin
                chk("b_odd_valid_out_1", valid_out_1, 1);
                chk("b_odd_data_out_1", data_out_1, bytes_b[i]);
            end
        end
        chk("b_credit_0", credit_0, 0);
        chk("b_credit_1", credit_1, 0);
        chk("b_ready_in", ready_in, 0);
        chk("b_err_drop_clear", err_drop, 0);

        // Ninth byte arrives while stalled and is dropped
        data_in = 8'hFF;
        step();
        valid_in = 1'b0;
        chk("drop_valid_out_0", valid_out_0, 0);
        chk("drop_valid_out_1", valid_out_1, 0);
        chk("drop_err_drop", err_drop, 1);
        chk("drop_data_out_0", data_out_0, 8'hB3);
        chk("drop_data_out_1", data_out_1, 8'hB4);

        // One credit back on lane 1 lets exactly one byte through
        pop_1 = 1'b1;
        step();
        pop_1 = 1'b0;
        chk("pop1_credit_1", credit_1, 1);
        chk("pop1_ready_in", ready_in, 1);
        chk("pop1_lane_sel", lane_sel, 1);
        valid_in = 1'b1;
        data_in  = 8'h55;
        step();
        valid_in = 1'b0;
        chk("b55_valid_out_1", valid_out_1, 1);
        chk("b55_data_out_1", data_out_1, 8'h55);
        chk("b55_valid_out_0", valid_out_0, 0);
        chk("b55_credit_1", credit_1, 0);
        chk("b55_ready_in", ready_in, 0);

        // Lane 0 empty, lane 1 at 3: every byte goes to lane 1
        pop_1 = 1'b1;
        step();
        step();
        step();
        pop_1 = 1'b0;
        chk("skip_credit_0", credit_0, 0);
        chk("skip_credit_1", credit_1, 3);
        valid_in = 1'b1;
        data_in  = 8'hC1;
        chk("c1_lane_sel", lane_sel, 1);
        step();
        chk("c1_valid_out_1", valid_out_1, 1);
        chk("c1_data_out_1", data_out_1, 8'hC1);
        chk("c1_credit_1", credit_1, 2);
        data_in = 8'hC2;
        chk("c2_lane_sel", lane_sel, 1);
        step();
        chk("c2_valid_out_1", valid_out_1, 1);
        chk("c2_valid_out_0", valid_out_0, 0);
        chk("c2_credit_1", credit_1, 1);
        data_in = 8'hC3;
        pop_1   = 1'b1;
        step();
        valid_in = 1'b0;
        pop_1    = 1'b0;
        chk("c3_data_out_1", data_out_1, 8'hC3);
        chk("c3_valid_out_1", valid_out_1, 1);
        chk("c3_credit_1", credit_1, 1);
        chk("c3_data_out_0_held", data_out_0, 8'hB3);

        // Refill lane 0, then overflow it with one extra return
        pop_0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        chk("refill_credit_0", credit_0, 4);
        chk("refill_err_credit", err_credit, 0);
        step();
        pop_0 = 1'b0;
        chk("over_credit_0", credit_0, 4);
        chk("over_err_credit", err_credit, 1);
        step();
        chk("over_err_credit_sticky", err_credit, 1);
        chk("err_drop_sticky", err_drop, 1);

        // Reset in the middle of traffic
        valid_in = 1'b1;
        data_in  = 8'hD1;
        step();
        chk("d1_valid_out_0", valid_out_0, 1);
        chk("d1_data_out_0", data_out_0, 8'hD1);
        data_in = 8'hD2;
        reset   = 1'b1;
        pop_1   = 1'b1;
        step();
        chk("mid_rst_valid_out_0", valid_out_0, 0);
        chk("mid_rst_valid_out_1", valid_out_1, 0);
        chk("mid_rst_data_out_0", data_out_0, 8'h00);
        chk("mid_rst_data_out_1", data_out_1, 8'h00);
        chk("mid_rst_credit_0", credit_0, 4);
        chk("mid_rst_credit_1", credit_1, 4);
        chk("mid_rst_err_drop", err_drop, 0);
        chk("mid_rst_err_credit", err_credit, 0);
        chk("mid_rst_ready_in", ready_in, 0);
        step();
        chk("rst_valid_err_drop", err_drop, 0);
        chk("rst_pop_err_credit", err_credit, 0);
        reset    = 1'b0;
        valid_in = 1'b0;
        pop_1    = 1'b0;
        #1;
        chk("post_rst_ready_in", ready_in, 1);
        chk("post_rst_lane_sel", lane_sel, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_lane_scheduler.md
Name: demux_lane_scheduler

Overview:
- Credit-based round-robin scheduler that steers an 8-bit valid-qualified byte stream onto two output lanes (lane 0, lane 1).
- Decides the lane for every accepted byte, tracks free downstream slots per lane, and back-pressures the source when neither lane has room.
- Sits in the clk_2f domain in front of the per-lane sinks, replacing the fixed alternating demux select with flow-controlled scheduling.

Parameters:
- CREDITS, 4: downstream slots per lane, and the reset/maximum credit count. Legal range is 1..15.
- CW, 4: credit counter width. Must hold CREDITS.

Ports:
- clk_2f  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  8  input byte.
- valid_in  input  1  data_in qualifier.
- ready_in  output  1  scheduler can accept this cycle.
- pop_0  input  1  lane 0 sink freed one slot (credit return).
- pop_1  input  1  lane 1 sink freed one slot (credit return).
- data_out_0  output  8  lane 0 byte, registered.
- data_out_1  output  8  lane 1 byte, registered.
- valid_out_0  output  1  data_out_0 valid, one-cycle pulse per byte.
- valid_out_1  output  1  data_out_1 valid, one-cycle pulse per byte.
- lane_sel  output  1  lane the next accepted byte will go to.
- credit_0  output  CW  current lane 0 credit count.
- credit_1  output  CW  current lane 1 credit count.
- err_drop  output  1  sticky; set when valid_in is seen while ready_in=0.
- err_credit  output  1  sticky; set when a pop arrives on a lane already at CREDITS.

Behaviour:
- Reset is sampled on the clock edge only. While reset=1 at an edge:
  - data_out_0 and data_out_1 clear to 8'h00; valid_out_0 and valid_out_1 clear to 0.
  - credit_0 and credit_1 load CREDITS.
  - FSM goes to PREF0; err_drop and err_credit clear.
  - ready_in is forced to 0 combinationally while reset=1.
  - Reset asserted mid-stream discards in-flight state; pops arriving during reset are ignored.
- ready_in is combinational: !reset && (credit_0!=0 || credit_1!=0).
- Accept condition: accept = valid_in && ready_in.
- FSM has three states: PREF0 (lane 0 preferred), PREF1 (lane 1 preferred), STALL (both credits 0).
- Target lane selection:
  - In PREF0: lane 0 if credit_0!=0, otherwise lane 1.
  - In PREF1: lane 1 if credit_1!=0, otherwise lane 0.
  - lane_sel is combinational and shows this target lane.
  - In STALL, lane_sel holds the last preferred lane.
- On accept:
  - The byte is registered into data_out_<target> and valid_out_<target>=1 on the next cycle, so latency is 1 clock.
  - The other lane's valid_out is 0 and its data_out holds its previous value.
  - Target credit is decremented.
  - Next preference is the lane opposite the target, i.e. strict alternation whenever both lanes have credit.
- No accept: both valid_out signals are 0 the next cycle and the data registers hold.
- Credit update per lane each cycle: next = credit - push + pop.
  - Simultaneous push and pop on the same lane leaves the credit unchanged.
  - A pop on a lane at 0 credit with no push gives 1.
- Pop at credit==CREDITS without a same-cycle push: the credit is held (it never exceeds CREDITS) and err_credit sets.
- STALL:
  - Entered when the next-state credits are both 0.
  - Left on the first cycle with any nonzero credit.
  - The next state is PREF of the lane that regained credit; if both regain credit in the same cycle, go to PREF of the lane after the last served lane.
- valid_in while ready_in=0 (stall or reset): the byte is dropped, not queued, and err_drop sets (sticky) unless reset=1.
- err flags clear only on reset.
- Timing: no combinational path from data_in to data_out. valid_in to ready_in is not combinational; ready_in depends on registered credits only.

Test Plan:
1. Reset with CREDITS=4 -> credit_0=credit_1=4, ready_in=1 after reset drops, valid_out_*=0, data_out_*=8'h00, lane_sel=0.
2. Send 4 bytes 8'hA1,A2,A3,A4 back-to-back with no pops:
   - A1 and A3 appear on lane 0; A2 and A4 appear on lane 1.
   - Each appears 1 cycle after acceptance.
   - Credits end at 2/2.
3. Continue with 4 more bytes, no pops:
   - After 8 accepts, credits are 0/0 and ready_in=0 the cycle after the 8th accept.
   - A 9th byte 8'hFF is dropped and err_drop=1.
   - Neither valid_out pulses for it.
4. From the 0/0 stall, pulse pop_1 once, then send 8'h55 -> 8'h55 appears on lane 1, credit_1 returns to 0, ready_in deasserts again.
5. With credit_0=0 and credit_1=3, send 3 bytes -> all 3 go to lane 1 (lane 0 skipped); on the cycle the 3rd byte is pushed, pop_1 is asserted and credit_1 ends at 1.
6. Remaining cases:
   - pop_0 at credit_0=4 -> credit_0 stays 4 and err_credit=1.
   - Assert reset mid-stream with bytes pending -> next cycle all outputs are at reset values and both err flags are 0.
